// File: rtl/sa_pkg.sv
// Shared widths and element types for the int8 systolic array column drain.
package sa_pkg;
    localparam int ACC_W = 19;
    localparam int OUT_W = 8;
    localparam int SH_W  = 5;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [OUT_W-1:0] q_t;
endpackage

// File: rtl/sa_col_drain_if.sv
// Output stream from a column drain to the output buffer (valid/ready, row-tagged).
interface sa_col_drain_if import sa_pkg::*; #(
    parameter int N_ROWS = 8
) ();
    localparam int ROW_W = $clog2(N_ROWS);

    logic signed [OUT_W-1:0] out_data;
    logic [ROW_W-1:0]        out_row;
    logic                    out_last;
    logic                    out_valid;
    logic                    out_ready;

    modport master (output out_data, out_row, out_last, out_valid, input out_ready);
    modport slave  (input out_data, out_row, out_last, out_valid, output out_ready);
endinterface

// File: rtl/sa_requant.sv
// Combinational requantizer: rounding arithmetic right shift (half toward +inf), then int8 saturation.
module sa_requant import sa_pkg::*; (
    input  acc_t            acc_in,
    input  logic [SH_W-1:0] shift_cfg,
    output q_t              q_out
);
    localparam logic signed [ACC_W:0] QMAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] QMIN = (ACC_W+1)'(-(2**(OUT_W-1)));

    // One guard bit keeps the rounding bias from wrapping at the positive extreme.
    function automatic logic signed [ACC_W:0] round_shift(acc_t v, logic [SH_W-1:0] s);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] bias;
        ext = {v[ACC_W-1], v};
        if (s == '0) return ext;
        bias = (ACC_W+1)'(1) << (s - 1'b1);
        return (ext + bias) >>> s;
    endfunction

    function automatic q_t saturate(logic signed [ACC_W:0] r);
        if (r > QMAX) return QMAX[OUT_W-1:0];
        if (r < QMIN) return QMIN[OUT_W-1:0];
        return r[OUT_W-1:0];
    endfunction

    assign q_out = saturate(round_shift(acc_in, shift_cfg));
endmodule

// File: rtl/sa_col_drain.sv
// Column drain: captures skewed per-row PE results, requantizes, and streams them out in row order.
module sa_col_drain import sa_pkg::*; #(
    parameter int N_ROWS = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic [N_ROWS*ACC_W-1:0] c_in,
    input  logic [N_ROWS-1:0]       c_valid_in,
    input  logic [SH_W-1:0]         shift_cfg,
    sa_col_drain_if.master          ob,
    output logic                    busy,
    output logic                    ovf_err,
    input  logic                    clr_err
);
    localparam int ROW_W = $clog2(N_ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

    acc_t              hold_p0 [N_ROWS];
    logic [N_ROWS-1:0] pend_p0;
    logic [ROW_W-1:0]  ptr;

    logic              out_free;
    logic              hs;
    logic              load;
    logic [N_ROWS-1:0] cap;
    logic [N_ROWS-1:0] ld_row;
    logic [N_ROWS-1:0] ovf_set;
    acc_t              rq_in;
    q_t                rq_out;

    always_comb begin
        out_free = !ob.out_valid || ob.out_ready;
        hs       = ob.out_valid && ob.out_ready;
        load     = EN && out_free && pend_p0[ptr];
        cap      = EN ? c_valid_in : '0;
        ld_row   = '0;
        ovf_set  = '0;
        for (int i = 0; i < N_ROWS; i++) begin
            ld_row[i]  = load && (ptr == ROW_W'(i));
            // A row being handed to the output frees its slot this cycle, so a new result is not an overrun.
            ovf_set[i] = cap[i] && pend_p0[i] && !ld_row[i];
        end
        rq_in = hold_p0[ptr];
        busy  = (|pend_p0) || ob.out_valid;
    end

    sa_requant u_requant (
        .acc_in    (rq_in),
        .shift_cfg (shift_cfg),
        .q_out     (rq_out)
    );

    // Stage p0 -> output register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            pend_p0      <= '0;
            ptr          <= '0;
            ovf_err      <= 1'b0;
            ob.out_data  <= '0;
            ob.out_row   <= '0;
            ob.out_last  <= 1'b0;
            ob.out_valid <= 1'b0;
            for (int i = 0; i < N_ROWS; i++) hold_p0[i] <= '0;
        end else begin
            for (int i = 0; i < N_ROWS; i++) begin
                if (cap[i] && (!pend_p0[i] || ld_row[i])) begin
                    hold_p0[i] <= c_in[i*ACC_W +: ACC_W];
                    pend_p0[i] <= 1'b1;
                end else if (ld_row[i]) begin
                    pend_p0[i] <= 1'b0;
                end
            end

            if (load) begin
                ob.out_data  <= rq_out;
                ob.out_row   <= ptr;
                ob.out_last  <= (ptr == LAST_ROW);
                ob.out_valid <= 1'b1;
                ptr          <= (ptr == LAST_ROW) ? '0 : ptr + ROW_W'(1);
            end else if (hs) begin
                ob.out_valid <= 1'b0;
            end

            if (|ovf_set)     ovf_err <= 1'b1;
            else if (clr_err) ovf_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sa_col_drain.sv
// Directed bench for sa_col_drain with an in-order output scoreboard.
module tb_sa_col_drain;
    import sa_pkg::*;

    localparam int N_ROWS = 8;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic                    EN;
    logic [N_ROWS*ACC_W-1:0] c_in;
    logic [N_ROWS-1:0]       c_valid_in;
    logic [SH_W-1:0]         shift_cfg;
    logic                    busy;
    logic                    ovf_err;
    logic                    clr_err;

    sa_col_drain_if #(.N_ROWS(N_ROWS)) ob ();

    sa_col_drain #(.N_ROWS(N_ROWS)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .c_in       (c_in),
        .c_valid_in (c_valid_in),
        .shift_cfg  (shift_cfg),
        .ob         (ob),
        .busy       (busy),
        .ovf_err    (ovf_err),
        .clr_err    (clr_err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q [$];
    logic [11:0] mon_e;

    int val_tab [4] = '{-262144, 2024, -9, 131071};
    int sh_tab  [4] = '{18, 4, 4, 17};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference requant by floor division, independent of shift arithmetic.
    function automatic int ref_q(int v, int s);
        int num, den, r;
        if (s == 0) r = v;
        else begin
            den = 1 << s;
            num = v + den / 2;
            r = num / den;
            if (num < 0 && (num % den) != 0) r = r - 1;
        end
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic push(input int row, input int val);
        logic signed [7:0] d;
        d = 8'(ref_q(val, int'(shift_cfg)));
        exp_q.push_back({d, 3'(row), (row == N_ROWS - 1)});
    endtask

    task automatic set_row(input int row, input int val);
        logic signed [ACC_W-1:0] t;
        t = ACC_W'(val);
        c_in[row*ACC_W +: ACC_W] = t;
        c_valid_in[row] = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((busy === 1'b1 || exp_q.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_queue"}, exp_q.size(), 0);
    endtask

    always @(negedge CLK) begin
        if (RST === 1'b1 && ob.out_valid === 1'b1 && ob.out_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out: observed row %0d data %0d expected none", ob.out_row, ob.out_data);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("out_data", ob.out_data, $signed(mon_e[11:4]));
                chk("out_row", ob.out_row, mon_e[3:1]);
                chk("out_last", ob.out_last, mon_e[0]);
            end
        end
    end

    initial begin
        RST = 1'b0; EN = 1'b1; c_in = '0; c_valid_in = '0; shift_cfg = 3; clr_err = 1'b0;
        ob.out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", ob.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_data", ob.out_data, 0);
        chk("rst_row", ob.out_row, 0);
        chk("rst_last", ob.out_last, 0);
        RST = 1'b1;

        // Skewed capture, one row per cycle
        shift_cfg = 3;
        for (int i = 0; i < N_ROWS; i++) begin
            c_valid_in = '0;
            set_row(i, 1000); push(i, 1000);
            tick();
            if (i == 0) chk("lat_not_yet", ob.out_valid, 0);
            if (i == 1) begin
                chk("lat_2cyc", ob.out_valid, 1);
                chk("lat_row0", ob.out_row, 0);
            end
        end
        c_valid_in = '0;
        drain("skew");

        // Requant corners
        shift_cfg = 3;
        set_row(0, 2000); set_row(1, -1030); push(0, 2000); push(1, -1030);
        tick(); c_valid_in = '0; drain("sat");
        shift_cfg = 1;
        set_row(2, -7); push(2, -7);
        tick(); c_valid_in = '0; drain("round_neg");
        shift_cfg = 0;
        set_row(3, 262143); push(3, 262143);
        tick(); c_valid_in = '0; drain("shift0");
        for (int i = 4; i < N_ROWS; i++) begin
            shift_cfg = SH_W'(sh_tab[i-4]);
            set_row(i, val_tab[i-4]); push(i, val_tab[i-4]);
            tick(); c_valid_in = '0; drain("rq_tab");
        end

        // Backpressure with all rows pending
        shift_cfg = 2;
        ob.out_ready = 1'b0;
        for (int i = 0; i < N_ROWS; i++) begin
            set_row(i, 100 * i - 300); push(i, 100 * i - 300);
        end
        tick(); c_valid_in = '0; tick();
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", ob.out_valid, 1);
            chk("bp_row", ob.out_row, 0);
            chk("bp_data", ob.out_data, -75);
            tick();
        end
        ob.out_ready = 1'b1;
        for (int k = 0; k < N_ROWS; k++) begin
            chk("bp_stream_row", ob.out_row, k);
            chk("bp_stream_valid", ob.out_valid, 1);
            if (k == N_ROWS - 1) chk("bp_busy_last", busy, 1);
            tick();
        end
        chk("bp_busy_done", busy, 0);
        chk("bp_valid_done", ob.out_valid, 0);
        drain("bp");

        // Out-of-order arrival
        shift_cfg = 0;
        set_row(3, 33); tick(); c_valid_in = '0;
        tick(); tick();
        chk("ooo_wait", ob.out_valid, 0);
        chk("ooo_busy", busy, 1);
        push(0, 10); push(1, 11); push(2, 12); push(3, 33);
        set_row(0, 10); tick(); c_valid_in = '0;
        set_row(1, 11); set_row(2, 12); tick(); c_valid_in = '0;
        drain("ooo");
        for (int i = 4; i < N_ROWS; i++) begin
            set_row(i, 36 + i); push(i, 36 + i);
        end
        tick(); c_valid_in = '0; drain("ooo_tail");

        // Overflow on a pending row while ptr waits at row 2
        set_row(0, 5); set_row(1, 6); push(0, 5); push(1, 6);
        tick(); c_valid_in = '0; drain("ovf_head");
        set_row(5, 55); tick(); c_valid_in = '0;
        chk("ovf_clean", ovf_err, 0);
        set_row(5, 99); tick(); c_valid_in = '0;
        chk("ovf_set", ovf_err, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("ovf_clr", ovf_err, 0);
        set_row(5, 77); clr_err = 1'b1; tick(); c_valid_in = '0; clr_err = 1'b0;
        chk("ovf_set_wins", ovf_err, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("ovf_clr2", ovf_err, 0);
        push(2, 20); push(3, 30); push(4, 40); push(5, 55); push(6, 60); push(7, 70);
        set_row(2, 20); set_row(3, 30); set_row(4, 40); set_row(6, 60); set_row(7, 70);
        tick(); c_valid_in = '0;
        tick(); tick(); tick();
        set_row(5, 88); tick(); c_valid_in = '0;
        chk("recap_no_ovf", ovf_err, 0);
        tick(); tick(); tick();
        for (int i = 0; i < N_ROWS; i++) begin
            if (i != 5) set_row(i, i + 1);
            push(i, (i == 5) ? 88 : i + 1);
        end
        tick(); c_valid_in = '0; drain("recap");
        chk("recap_ovf_end", ovf_err, 0);

        // Stall: no capture while EN=0; handshake still completes
        EN = 1'b0;
        set_row(0, 3); set_row(1, 4); tick(); c_valid_in = '0;
        EN = 1'b1;
        chk("stall_busy", busy, 0);
        tick();
        chk("stall_valid", ob.out_valid, 0);
        set_row(0, 9); push(0, 9); tick(); c_valid_in = '0; tick();
        chk("en0_pre_valid", ob.out_valid, 1);
        EN = 1'b0; tick();
        chk("en0_hs_drop", ob.out_valid, 0);
        EN = 1'b1;

        // Reset mid-tile
        ob.out_ready = 1'b0;
        set_row(1, 17); set_row(2, 18); set_row(3, 19);
        tick(); c_valid_in = '0; tick();
        chk("mid_valid", ob.out_valid, 1);
        chk("mid_data", ob.out_data, 17);
        RST = 1'b0; tick();
        chk("mrst_valid", ob.out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_data", ob.out_data, 0);
        chk("mrst_row", ob.out_row, 0);
        chk("mrst_last", ob.out_last, 0);
        RST = 1'b1; ob.out_ready = 1'b1;
        set_row(0, -5); push(0, -5); tick(); c_valid_in = '0; tick();
        chk("post_rst_row", ob.out_row, 0);
        chk("post_rst_valid", ob.out_valid, 1);
        drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sa_col_drain.md
Name: sa_col_drain

Overview:
- Downstream drain for one column of the int8 systolic array.
- Captures each PE's 19-bit dot-product result on that PE's one-cycle C_valid pulse. Results arrive skewed in time across rows.
- Requantizes each result to int8 by rounding arithmetic right shift plus saturation.
- Emits results in row order 0..N_ROWS-1 on a valid/ready stream to the output buffer, with a last flag per tile.

Parameters:
- N_ROWS, 8, number of PEs (rows) drained by this column.
- ACC_W, 19, PE accumulator width (signed).
- OUT_W, 8, output element width (signed).
- SH_W, 5, width of shift configuration.

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous reset, active-low
- EN  input  1  global stall-enable, shared with PEs
- c_in  input  N_ROWS*ACC_W  packed PE results; row i at bits [i*ACC_W +: ACC_W]
- c_valid_in  input  N_ROWS  per-row result strobe (one-cycle pulse)
- shift_cfg  input  SH_W  requant right-shift amount, 0..ACC_W-1; quasi-static, changed only while busy=0
- out_data  output  OUT_W  requantized signed result
- out_row  output  $clog2(N_ROWS)  row index of out_data
- out_last  output  1  high with row N_ROWS-1 element
- out_valid  output  1  stream valid
- out_ready  input  1  stream ready
- busy  output  1  any row pending or out_valid high
- ovf_err  output  1  sticky: result arrived at an already-pending row
- clr_err  input  1  clears ovf_err

Behaviour:

Reset (RST=0 at posedge):
- pending bits, hold registers, out_data, out_row, out_last, out_valid, ovf_err, and row pointer ptr all go to 0.
- Takes effect mid-tile as well: all captured data is discarded and no handshake completes in that cycle.

Capture (EN=1 only):
- For each i with c_valid_in[i]=1 and pending[i]=0: hold[i] <= c_in row i, pending[i] <= 1.
- If pending[i]=1 and row i is not being loaded to the output this cycle: the new value is dropped, hold[i] is kept, and ovf_err <= 1.
- If row i is being loaded to the output in the same cycle: the new value is captured and pending[i] stays 1; this is not an error.

Output register:
- out_free = !out_valid || out_ready.
- Handshake completes when out_valid && out_ready.
- If EN=1 && out_free && pending[ptr]:
  - out_data <= requant(hold[ptr]); out_row <= ptr; out_last <= (ptr==N_ROWS-1); out_valid <= 1.
  - Clear pending[ptr], unless it is being recaptured in the same cycle.
  - ptr <= ptr+1, wrapping N_ROWS-1 -> 0.
- Else, if a handshake completes: out_valid <= 0.
- While out_valid=1 && out_ready=0: out_data, out_row and out_last are held stable.
- EN=0: no capture, no load, ptr frozen. A handshake still completes and drops out_valid.

Ordering and latency:
- Strictly in row order. A pending later row waits for ptr to reach it.
- With out_ready=1 and ptr waiting on row i: c_valid_in[i] sampled at edge t produces out_valid=1 after edge t+1 (2-cycle latency).
- Throughput is 1 element/cycle when rows are already pending.

Requant:
- s = shift_cfg.
- If s=0: r = hold.
- Else: r = (sext(hold, ACC_W+1) + (1<<(s-1))) >>> s, i.e. round half toward +inf.
- Saturate r to [-128, 127].

Error flag:
- ovf_err is cleared by clr_err=1 (independent of EN).
- A set event in the same cycle as clr_err wins: ovf_err=1.

Busy:
- busy = |pending || out_valid (combinational).

Decomposition:
- Package sa_pkg: ACC_W, OUT_W, SH_W constants; typedef acc_t (logic signed [ACC_W-1:0]); typedef q_t (logic signed [OUT_W-1:0]).
- Sub-module sa_requant: combinational; acc_t in + shift_cfg -> q_t out; rounding and saturation as above; unit-tested standalone.
- Top module holds pending/hold arrays, ptr counter and output register.

Test Plan:
1. Skewed capture: shift_cfg=3, out_ready=1; rows 0..7 pulse on consecutive cycles with c_in=1000 -> eight outputs of 125, out_row 0..7 in order, out_last only with row 7, first out_valid 2 cycles after row-0 pulse.
2. Requant corners, shift_cfg=3: c_in=2000 -> 127; c_in=-1030 -> -128; c_in=-7 with shift_cfg=1 -> -3; c_in=262143 with shift_cfg=0 -> 127.
3. Backpressure: out_ready=0 for 10 cycles after row 0 loads, all rows pending -> out_data and out_row held (row 0); release -> rows 1..7 one per cycle; busy falls after the row-7 handshake.
4. Out-of-order arrival: row 3 pulses before row 0 -> row 3 is not emitted until row 0 is captured and emitted; then rows 0,1,2,3 in order.
5. Overflow: second pulse on row 5 while row 5 is pending and ptr=2 stalled -> ovf_err=1, first value emitted for row 5; clr_err=1 -> ovf_err=0 next cycle.
6. Stall and reset: EN=0 during pulses -> nothing captured. RST=0 mid-tile with rows pending -> all outputs 0, busy=0 next cycle; new tile then starts at row 0.
